// File: rtl/gpu_mem_coalescer_if.sv
// Warp memory port bundle between core, coalescer and single-port data memory.
// Latency: none (wires only).
// Backpressure: req_valid/req_ready on the core side, mem_req_valid/mem_req_ready on the memory side.
interface gpu_mem_coalescer_if #(
    parameter int NUM_THREADS = 4,
    parameter int DATA_WIDTH  = 16
);
    logic                                   req_valid;
    logic                                   req_ready;
    logic                                   req_we;
    logic [NUM_THREADS-1:0]                 req_mask;
    logic [NUM_THREADS-1:0][DATA_WIDTH-1:0] req_addr;
    logic [NUM_THREADS-1:0][DATA_WIDTH-1:0] req_wdata;
    logic                                   resp_valid;
    logic [NUM_THREADS-1:0][DATA_WIDTH-1:0] resp_rdata;
    logic                                   mem_req_valid;
    logic                                   mem_req_ready;
    logic                                   mem_we;
    logic [DATA_WIDTH-1:0]                  mem_addr;
    logic [DATA_WIDTH-1:0]                  mem_wdata;
    logic                                   mem_rvalid;
    logic [DATA_WIDTH-1:0]                  mem_rdata;
    logic [15:0]                            txn_count;

    // Coalescer side of the bundle.
    modport slave (
        input  req_valid, req_we, req_mask, req_addr, req_wdata,
        input  mem_req_ready, mem_rvalid, mem_rdata,
        output req_ready, resp_valid, resp_rdata,
        output mem_req_valid, mem_we, mem_addr, mem_wdata, txn_count
    );

    // Environment side: the core plus the data memory.
    modport master (
        output req_valid, req_we, req_mask, req_addr, req_wdata,
        output mem_req_ready, mem_rvalid, mem_rdata,
        input  req_ready, resp_valid, resp_rdata,
        input  mem_req_valid, mem_we, mem_addr, mem_wdata, txn_count
    );
endinterface

// File: rtl/gpu_mem_coalescer.sv
// Serialises one warp LDR/STR into single-word memory transactions, merging same-address load lanes.
// Latency: zero-wait memory gives load 2K+1 (K distinct addresses), store N+1, empty mask 1 cycle.
// Backpressure: req_ready low while an op is in flight; issue outputs hold while mem_req_ready is low.
module gpu_mem_coalescer #(
    parameter int NUM_THREADS = 4,
    parameter int DATA_WIDTH  = 16
) (
    input  logic                clk,
    input  logic                rst,
    gpu_mem_coalescer_if.slave  bus
);
    localparam int LW = (NUM_THREADS > 1) ? $clog2(NUM_THREADS) : 1;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_WAIT  = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    logic [1:0]                             state;
    logic                                   we_r;
    logic [NUM_THREADS-1:0][DATA_WIDTH-1:0] addr_r;
    logic [NUM_THREADS-1:0][DATA_WIDTH-1:0] wdata_r;
    logic [NUM_THREADS-1:0][DATA_WIDTH-1:0] rdata_r;
    logic [NUM_THREADS-1:0]                 pending;
    logic [NUM_THREADS-1:0]                 inflight;
    logic [15:0]                            txn_count_r;

    logic [LW-1:0]                          lane;
    logic                                   lane_found;
    logic [NUM_THREADS-1:0]                 lane_bit;
    logic [NUM_THREADS-1:0]                 match;
    logic [NUM_THREADS-1:0]                 pending_after_store;
    logic [NUM_THREADS-1:0]                 pending_after_load;

    // Pick the lowest pending lane and find every pending lane sharing its address.
    always_comb begin
        lane       = '0;
        lane_found = 1'b0;
        lane_bit   = '0;
        match      = '0;
        for (int i = 0; i < NUM_THREADS; i++) begin
            if (pending[i] && !lane_found) begin
                lane       = LW'(i);
                lane_found = 1'b1;
            end
        end
        lane_bit[lane] = 1'b1;
        for (int i = 0; i < NUM_THREADS; i++) begin
            match[i] = pending[i] && (addr_r[i] == addr_r[lane]);
        end
    end

    assign pending_after_store = pending & ~lane_bit;
    assign pending_after_load  = pending & ~inflight;

    assign bus.req_ready     = (state == S_IDLE);
    assign bus.resp_valid    = (state == S_DONE);
    assign bus.resp_rdata    = rdata_r;
    assign bus.mem_req_valid = (state == S_ISSUE);
    assign bus.mem_we        = (state == S_ISSUE) ? we_r : 1'b0;
    assign bus.mem_addr      = (state == S_ISSUE) ? addr_r[lane] : '0;
    assign bus.mem_wdata     = (state == S_ISSUE) ? wdata_r[lane] : '0;
    assign bus.txn_count     = txn_count_r;

    // Op sequencing: accept, issue one word at a time, collect read data, report completion.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= S_IDLE;
            we_r        <= 1'b0;
            addr_r      <= '0;
            wdata_r     <= '0;
            rdata_r     <= '0;
            pending     <= '0;
            inflight    <= '0;
            txn_count_r <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (bus.req_valid) begin
                        we_r     <= bus.req_we;
                        addr_r   <= bus.req_addr;
                        wdata_r  <= bus.req_wdata;
                        pending  <= bus.req_mask;
                        inflight <= '0;
                        rdata_r  <= '0;
                        state    <= (bus.req_mask == '0) ? S_DONE : S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    if (bus.mem_req_ready) begin
                        txn_count_r <= txn_count_r + 16'd1;
                        if (we_r) begin
                            // Stores go out lane by lane so the highest lane wins on a shared address.
                            pending <= pending_after_store;
                            state   <= (pending_after_store == '0) ? S_DONE : S_ISSUE;
                        end else begin
                            inflight <= match;
                            state    <= S_WAIT;
                        end
                    end
                end
                S_WAIT: begin
                    if (bus.mem_rvalid) begin
                        for (int i = 0; i < NUM_THREADS; i++) begin
                            if (inflight[i]) begin
                                rdata_r[i] <= bus.mem_rdata;
                            end
                        end
                        pending  <= pending_after_load;
                        inflight <= '0;
                        state    <= (pending_after_load == '0) ? S_DONE : S_ISSUE;
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_gpu_mem_coalescer.sv
// Scoreboard bench for gpu_mem_coalescer: directed cases then randomized warp ops.
// A memory responder checks every issued word; a response monitor checks lane data, count and latency.
`timescale 1ns/1ps
module tb_gpu_mem_coalescer;
    localparam int NT = 4;
    localparam int DW = 16;

    typedef logic [NT-1:0][DW-1:0] lanes_t;
    typedef struct {
        logic          we;
        logic [DW-1:0] addr;
        logic [DW-1:0] wdata;
    } txn_t;
    typedef struct {
        lanes_t      rdata;
        logic [15:0] txn;
        int          lat;
        int          t_acc;
    } resp_t;

    logic clk = 1'b0;
    logic rst;
    int   cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    gpu_mem_coalescer_if #(.NUM_THREADS(NT), .DATA_WIDTH(DW)) bus ();

    gpu_mem_coalescer #(.NUM_THREADS(NT), .DATA_WIDTH(DW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int vectors     = 0;
    int miscompares = 0;

    txn_t  exp_txn[$];
    resp_t exp_resp[$];
    logic [DW-1:0] mem_arr [logic [DW-1:0]];
    logic [DW-1:0] ref_mem [logic [DW-1:0]];
    logic [15:0]   ref_txn   = 16'd0;
    bit            zero_wait = 1'b1;
    bit            drop_rvalid = 1'b0;
    bit            stray_rv  = 1'b0;
    int            stall_cnt = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h required %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic fail_now(input string name);
        vectors++;
        miscompares++;
        $display("FAIL %s (cycle %0d)", name, cyc);
    endtask

    function automatic lanes_t mk(input logic [DW-1:0] a0, a1, a2, a3);
        lanes_t v;
        v[0] = a0; v[1] = a1; v[2] = a2; v[3] = a3;
        return v;
    endfunction

    // Uninitialised memory reads back as address + 10.
    function automatic logic [DW-1:0] rd_mem(input logic [DW-1:0] a);
        return mem_arr.exists(a) ? mem_arr[a] : a + 16'd10;
    endfunction

    function automatic logic [DW-1:0] rd_ref(input logic [DW-1:0] a);
        return ref_mem.exists(a) ? ref_mem[a] : a + 16'd10;
    endfunction

    // Reference model: one transaction per active store lane, one per distinct load address
    // in order of first appearance; every active load lane gets the word at its address.
    task automatic model_op(input logic we, input logic [NT-1:0] mask, input lanes_t addr,
                            input lanes_t wdata, input bit lat_chk, input int t_acc);
        logic [DW-1:0] seen[$];
        resp_t r;
        int    ntx = 0;
        r.rdata = '0;
        for (int i = 0; i < NT; i++) begin
            if (mask[i]) begin
                if (we) begin
                    exp_txn.push_back('{1'b1, addr[i], wdata[i]});
                    ref_mem[addr[i]] = wdata[i];
                    ntx++;
                end else begin
                    int hits[$];
                    hits = seen.find_index(x) with (x == addr[i]);
                    if (hits.size() == 0) begin
                        seen.push_back(addr[i]);
                        exp_txn.push_back('{1'b0, addr[i], '0});
                        ntx++;
                    end
                    r.rdata[i] = rd_ref(addr[i]);
                end
            end
        end
        ref_txn = ref_txn + 16'(ntx);
        r.txn   = ref_txn;
        r.lat   = lat_chk ? (we ? ntx + 1 : 2 * ntx + 1) : -1;
        r.t_acc = t_acc;
        exp_resp.push_back(r);
    endtask

    task automatic wait_ready(output bit ok);
        int n = 0;
        @(negedge clk);
        while (bus.req_ready !== 1'b1 && n < 1000) begin
            @(negedge clk);
            n++;
        end
        ok = (n < 1000);
        if (!ok) fail_now("req_ready_timeout");
    endtask

    task automatic run_op(input logic we, input logic [NT-1:0] mask, input lanes_t addr,
                          input lanes_t wdata, input bit zw, input int stall);
        bit ok;
        wait_ready(ok);
        if (!ok) return;
        zero_wait     = zw;
        stall_cnt     = stall;
        bus.req_valid = 1'b1;
        bus.req_we    = we;
        bus.req_mask  = mask;
        bus.req_addr  = addr;
        bus.req_wdata = wdata;
        model_op(we, mask, addr, wdata, zw && (stall == 0), cyc + 1);
        @(negedge clk);
        bus.req_valid = 1'b0;
        bus.req_mask  = 4'($urandom);
        bus.req_addr  = lanes_t'({$urandom, $urandom});
    endtask

    // Memory responder: checks each accepted word against the expected transaction stream.
    initial begin
        logic          prev_stall;
        txn_t          prev;
        txn_t          t;
        int            rd_wait;
        logic [DW-1:0] rd_data;
        prev_stall = 1'b0;
        prev       = '{1'b0, '0, '0};
        rd_wait    = 0;
        rd_data    = '0;
        bus.mem_req_ready = 1'b0;
        bus.mem_rvalid    = 1'b0;
        bus.mem_rdata     = '0;
        forever begin
            @(negedge clk);
            bus.mem_rvalid = 1'b0;
            if (rd_wait > 0) begin
                rd_wait--;
                if (rd_wait == 0 && !drop_rvalid) begin
                    bus.mem_rvalid = 1'b1;
                    bus.mem_rdata  = rd_data;
                end
            end
            if (stray_rv) begin
                bus.mem_rvalid = 1'b1;
                bus.mem_rdata  = 16'hBEEF;
                stray_rv       = 1'b0;
            end
            if (prev_stall) begin
                check("stall_hold", 64'({bus.mem_req_valid, bus.mem_we, bus.mem_addr, bus.mem_wdata}),
                      64'({1'b1, prev.we, prev.addr, prev.wdata}));
            end
            if (stall_cnt > 0 && bus.mem_req_valid === 1'b1) begin
                bus.mem_req_ready = 1'b0;
                stall_cnt--;
            end else begin
                bus.mem_req_ready = zero_wait ? 1'b1 : ($urandom_range(0, 2) != 0);
            end
            prev_stall = (bus.mem_req_valid === 1'b1) && !bus.mem_req_ready;
            prev       = '{bus.mem_we, bus.mem_addr, bus.mem_wdata};
            if (bus.mem_req_valid === 1'b1 && bus.mem_req_ready) begin
                if (exp_txn.size() == 0) begin
                    fail_now("unexpected_mem_txn");
                end else begin
                    t = exp_txn.pop_front();
                    check("txn_we", 64'(bus.mem_we), 64'(t.we));
                    check("txn_addr", 64'(bus.mem_addr), 64'(t.addr));
                    if (t.we) check("txn_wdata", 64'(bus.mem_wdata), 64'(t.wdata));
                end
                if (bus.mem_we) begin
                    mem_arr[bus.mem_addr] = bus.mem_wdata;
                end else begin
                    rd_data = rd_mem(bus.mem_addr);
                    rd_wait = zero_wait ? 1 : $urandom_range(1, 4);
                end
            end
        end
    end

    // Response monitor: lane data, transaction count and zero-wait latency.
    initial begin
        resp_t r;
        forever begin
            @(negedge clk);
            if (bus.resp_valid !== 1'b0) begin
                if (exp_resp.size() == 0) begin
                    fail_now("unexpected_resp_valid");
                end else begin
                    r = exp_resp.pop_front();
                    check("resp_rdata", 64'(bus.resp_rdata), 64'(r.rdata));
                    check("txn_count", 64'(bus.txn_count), 64'(r.txn));
                    if (r.lat >= 0) check("resp_latency", 64'(cyc + 1 - r.t_acc), 64'(r.lat));
                end
            end
        end
    end

    // Stimulus: reset, directed cases, reset during WAIT, then random ops.
    initial begin
        bit ok;
        int n;
        int t_acc;
        rst           = 1'b1;
        bus.req_valid = 1'b0;
        bus.req_we    = 1'b0;
        bus.req_mask  = '0;
        bus.req_addr  = '0;
        bus.req_wdata = '0;
        repeat (3) @(negedge clk);
        check("rst_req_ready", 64'(bus.req_ready), 64'(1));
        check("rst_resp_valid", 64'(bus.resp_valid), 64'(0));
        check("rst_mem_req", 64'({bus.mem_req_valid, bus.mem_we, bus.mem_addr, bus.mem_wdata}), 64'(0));
        check("rst_rdata", 64'(bus.resp_rdata), 64'(0));
        check("rst_txn_count", 64'(bus.txn_count), 64'(0));
        rst = 1'b0;

        run_op(1'b0, 4'b1111, mk(0, 1, 2, 3), mk(0, 0, 0, 0), 1'b1, 0);
        mem_arr[16'd5] = 16'h00AB;
        ref_mem[16'd5] = 16'h00AB;
        run_op(1'b0, 4'b1111, mk(5, 5, 5, 5), mk(0, 0, 0, 0), 1'b1, 0);
        run_op(1'b1, 4'b0101, mk(7, 16'h3333, 7, 16'h4444), mk(16'h11, 16'h99, 16'h22, 16'h98), 1'b1, 0);
        run_op(1'b0, 4'b0001, mk(7, 1, 2, 3), mk(0, 0, 0, 0), 1'b1, 0);
        run_op(1'b0, 4'b0010, mk(16'h40, 9, 16'h41, 16'h42), mk(0, 0, 0, 0), 1'b1, 3);
        run_op(1'b0, 4'b0000, mk(1, 2, 3, 4), mk(0, 0, 0, 0), 1'b1, 0);

        // Reset while the coalescer waits for read data; the dropped op must never report.
        wait_ready(ok);
        if (ok) begin
            drop_rvalid   = 1'b1;
            zero_wait     = 1'b1;
            bus.req_valid = 1'b1;
            bus.req_we    = 1'b0;
            bus.req_mask  = 4'b0001;
            bus.req_addr  = mk(3, 0, 0, 0);
            exp_txn.push_back('{1'b0, 16'd3, '0});
            @(negedge clk);
            bus.req_valid = 1'b0;
            @(negedge clk);
            check("in_wait_before_reset", 64'({bus.req_ready, bus.mem_req_valid}), 64'(0));
            rst = 1'b1;
            #1;
            check("midrst_req_ready", 64'(bus.req_ready), 64'(1));
            check("midrst_resp_valid", 64'(bus.resp_valid), 64'(0));
            check("midrst_mem_req", 64'({bus.mem_req_valid, bus.mem_we, bus.mem_addr, bus.mem_wdata}), 64'(0));
            check("midrst_rdata", 64'(bus.resp_rdata), 64'(0));
            check("midrst_txn_count", 64'(bus.txn_count), 64'(0));
            ref_txn = 16'd0;
            @(negedge clk);
            rst         = 1'b0;
            drop_rvalid = 1'b0;
            stray_rv    = 1'b1;
            repeat (4) @(negedge clk);
            check("post_stray_req_ready", 64'(bus.req_ready), 64'(1));
            check("post_stray_txn_count", 64'(bus.txn_count), 64'(0));
            check("post_stray_rdata", 64'(bus.resp_rdata), 64'(0));
        end

        for (int k = 0; k < 150; k++) begin
            lanes_t a;
            lanes_t d;
            for (int i = 0; i < NT; i++) begin
                a[i] = 16'($urandom_range(0, 7));
                d[i] = 16'($urandom);
            end
            if ($urandom_range(0, 9) == 0) a[$urandom_range(0, 3)] = 16'hFFF8;
            run_op(1'($urandom), 4'($urandom), a, d, 1'($urandom), 0);
        end

        n = 0;
        while ((exp_resp.size() != 0 || exp_txn.size() != 0) && n < 2000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 2000) fail_now("drain_timeout");
        t_acc = cyc;
        repeat (3) @(negedge clk);
        check("final_idle", 64'(bus.req_ready), 64'(1));
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
